// File: rtl/row_prefetch_pkg.sv
// Shared sizes, timing constants and types for the row_prefetch line fetcher.
package row_prefetch_pkg;

  localparam int WORD_SIZE         = 32;
  localparam int LOG_WORD_SIZE     = 5;
  localparam int BOARD_SIZE        = 256;
  localparam int LOG_BOARD_SIZE    = 8;
  localparam int WORDS_PER_ROW     = BOARD_SIZE / WORD_SIZE;
  localparam int LOG_WORDS_PER_ROW = $clog2(WORDS_PER_ROW);
  localparam int LOG_MAX_ADDR      = LOG_BOARD_SIZE + LOG_WORDS_PER_ROW;

  localparam int VIEW_SIZE         = 64;
  localparam int LOG_VIEW_SIZE     = $clog2(VIEW_SIZE);
  localparam int LOG_CELL_SIZE     = 4;
  localparam int VIEW_PIX          = VIEW_SIZE << LOG_CELL_SIZE;

  localparam int H_ACTIVE          = 1024;
  localparam int H_TOTAL           = 1344;
  localparam int V_TOTAL           = 806;

  // Enough words to cover VIEW_SIZE cells starting at any bit offset.
  localparam int NWORDS            = (VIEW_SIZE + WORD_SIZE - 1 + WORD_SIZE - 1) / WORD_SIZE;
  localparam int LOG_NWORDS        = $clog2(NWORDS);

  typedef logic [LOG_BOARD_SIZE-1:0] pos_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    ASSEMBLE,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/row_prefetch_assemble.sv
// row_assemble: funnel shift of the fetched words so the view origin cell lands in the MSB.
module row_assemble
  import row_prefetch_pkg::*;
(
  input  logic [NWORDS*WORD_SIZE-1:0] words,
  input  logic [LOG_WORD_SIZE-1:0]    shift,
  output logic [VIEW_SIZE-1:0]        line
);

  localparam int SPARE = NWORDS * WORD_SIZE - VIEW_SIZE;
  localparam int RSW   = $clog2(SPARE + 1);

  // Left-shift-then-take-MSBs expressed as a right shift, so every input bit is consumed.
  logic [RSW-1:0] rsh;

  assign rsh  = RSW'(SPARE) - RSW'(shift);
  assign line = VIEW_SIZE'(words >> rsh);

endmodule

// File: rtl/row_prefetch.sv
// row_prefetch: fetches the next display line's cell row during hblank and streams one alive bit per pixel.
// Build option TORUS_WRAP_EN: board wraps in x and y; otherwise cells beyond the board edge read as dead.
//
// state    | meaning
// IDLE     | waiting for the hblank trigger
// ISSUE    | one board read per cycle, NWORDS reads
// DRAIN    | waiting for outstanding read data
// ASSEMBLE | shift slots into the fill buffer
// DONE     | fill buffer ready, waiting for swap
module row_prefetch
  import row_prefetch_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_y_in,
  input  logic [WORD_SIZE-1:0]      data_r_in,
  output logic [LOG_MAX_ADDR-1:0]   addr_r_out,
  output logic                      rd_en_out,
  output logic                      is_alive_out,
  output logic                      busy_out,
  output logic                      underrun_out
);

`ifdef TORUS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int IW  = (LOG_NWORDS > 0) ? LOG_NWORDS : 1;
  localparam int WW  = LOG_WORDS_PER_ROW + 1;
  localparam int RSW = LOG_BOARD_SIZE + 1;

  fetch_state_t state, state_nxt;

  logic                         trigger, swap, new_frame, off_view, in_view;
  logic [10:0]                  next_v;
  pos_t                         vx_q, vy_q, vx_use, vy_use;
  logic [RSW-1:0]               row_sum;
  pos_t                         row_q;
  logic                         row_oob_q;
  logic [LOG_WORDS_PER_ROW-1:0] word_base_q;
  logic [LOG_WORD_SIZE-1:0]     shift_q;
  logic [IW-1:0]                issue_idx_q;
  logic [WW-1:0]                word_sum;
  logic                         word_skip;

  logic [RD_LAT-1:0]            pv_q;
  logic [IW-1:0]                pslot_q [RD_LAT];
  logic [WORD_SIZE-1:0]         slot_q  [NWORDS];
  logic [NWORDS*WORD_SIZE-1:0]  words_cat;
  logic [VIEW_SIZE-1:0]         asm_line, fill_q, active_q;
  logic [LOG_VIEW_SIZE-1:0]     cx;

  assign trigger   = (hcount_in == 11'(H_ACTIVE));
  assign swap      = (hcount_in == 11'(H_TOTAL - 1));
  assign next_v    = (vcount_in == 10'(V_TOTAL - 1)) ? '0 : ({1'b0, vcount_in} + 11'd1);
  assign new_frame = (next_v == '0);
  assign off_view  = (next_v >= 11'(VIEW_PIX));

  // The view is sampled only at the start of a frame so all lines agree.
  assign vx_use = new_frame ? view_x_in : vx_q;
  assign vy_use = new_frame ? view_y_in : vy_q;

  assign row_sum   = {1'b0, vy_use} + RSW'(next_v >> LOG_CELL_SIZE);
  assign word_sum  = {1'b0, word_base_q} + WW'(issue_idx_q);
  assign word_skip = !WRAP && (word_sum[WW-1] || row_oob_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (swap) begin
      state_nxt = IDLE;
    end else if (trigger) begin
      state_nxt = off_view ? DONE : ISSUE;
    end else begin
      case (state)
        ISSUE:    if (issue_idx_q == IW'(NWORDS - 1)) state_nxt = DRAIN;
        DRAIN:    if (pv_q == '0) state_nxt = ASSEMBLE;
        ASSEMBLE: state_nxt = DONE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_en_out  = 1'b0;
    addr_r_out = '0;
    busy_out   = 1'b0;
    case (state)
      ISSUE: begin
        busy_out   = 1'b1;
        rd_en_out  = !word_skip;
        addr_r_out = {row_q, word_sum[WW-2:0]};
      end
      DRAIN, ASSEMBLE: busy_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vx_q        <= '0;
      vy_q        <= '0;
      row_q       <= '0;
      row_oob_q   <= 1'b0;
      word_base_q <= '0;
      shift_q     <= '0;
      issue_idx_q <= '0;
    end else if (trigger) begin
      if (new_frame) begin
        vx_q <= view_x_in;
        vy_q <= view_y_in;
      end
      row_q       <= row_sum[LOG_BOARD_SIZE-1:0];
      row_oob_q   <= row_sum[LOG_BOARD_SIZE];
      word_base_q <= vx_use[LOG_BOARD_SIZE-1 -: LOG_WORDS_PER_ROW];
      shift_q     <= vx_use[LOG_WORD_SIZE-1:0];
      issue_idx_q <= '0;
    end else if (state == ISSUE) begin
      issue_idx_q <= issue_idx_q + IW'(1);
    end
  end

  // Read tracking pipe: each stage carries a valid bit and the slot the data belongs to.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pslot_q[i] <= '0;
    end else if (trigger || swap) begin
      pv_q <= '0;
    end else begin
      pv_q[0]    <= rd_en_out;
      pslot_q[0] <= issue_idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pslot_q[i] <= pslot_q[i-1];
      end
    end
  end

  // Slots start at zero each fetch, so skipped words stay dead.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NWORDS; k++) slot_q[k] <= '0;
    end else if (trigger) begin
      for (int k = 0; k < NWORDS; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < NWORDS; k++)
        if (pv_q[RD_LAT-1] && pslot_q[RD_LAT-1] == IW'(k)) slot_q[k] <= data_r_in;
    end
  end

  always_comb begin
    words_cat = '0;
    for (int k = 0; k < NWORDS; k++)
      words_cat[(NWORDS-1-k)*WORD_SIZE +: WORD_SIZE] = slot_q[k];
  end

  row_assemble u_assemble (
    .words (words_cat),
    .shift (shift_q),
    .line  (asm_line)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fill_q       <= '0;
      active_q     <= '0;
      underrun_out <= 1'b0;
    end else begin
      if (trigger && off_view)    fill_q <= '0;
      else if (state == ASSEMBLE) fill_q <= asm_line;
      if (swap) active_q <= (state == DONE) ? fill_q : '0;
      if ((swap && state != DONE) || (trigger && busy_out)) underrun_out <= 1'b1;
    end
  end

  assign cx      = LOG_VIEW_SIZE'(hcount_in >> LOG_CELL_SIZE);
  assign in_view = (hcount_in < 11'(VIEW_PIX)) && ({1'b0, vcount_in} < 11'(VIEW_PIX));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)    is_alive_out <= 1'b0;
    else if (in_view) is_alive_out <= active_q[LOG_VIEW_SIZE'(VIEW_SIZE - 1) - cx];
    else              is_alive_out <= 1'b0;
  end

endmodule

// File: tb/tb_row_prefetch.sv
// Scoreboard bench for row_prefetch: expected reads and pixels are queued by the driver, popped by monitors.
module tb_row_prefetch;
  import row_prefetch_pkg::*;

  logic                      clk_in = 1'b0;
  logic                      rst_n_in = 1'b1;
  logic [10:0]               hcount_in = '0;
  logic [9:0]                vcount_in = '0;
  logic [LOG_BOARD_SIZE-1:0] view_x_in = '0;
  logic [LOG_BOARD_SIZE-1:0] view_y_in = '0;
  logic [WORD_SIZE-1:0]      data_r_in = '0;
  logic [LOG_MAX_ADDR-1:0]   addr_r_out;
  logic                      rd_en_out, is_alive_out, busy_out, underrun_out;

  row_prefetch #(.RD_LAT(2)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .view_x_in    (view_x_in),
    .view_y_in    (view_y_in),
    .data_r_in    (data_r_in),
    .addr_r_out   (addr_r_out),
    .rd_en_out    (rd_en_out),
    .is_alive_out (is_alive_out),
    .busy_out     (busy_out),
    .underrun_out (underrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Board memory with a two-cycle read latency.
  logic [WORD_SIZE-1:0] mem [1 << LOG_MAX_ADDR];
  logic [WORD_SIZE-1:0] rd_s1 = '0;
  always @(posedge clk_in) begin
    rd_s1     <= rd_en_out ? mem[addr_r_out] : '0;
    data_r_in <= rd_s1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  typedef struct {
    int   h;
    logic alive;
  } pix_exp_t;

  pix_exp_t pix_q[$];
  int       rd_q[$];
  logic     pix_chk = 1'b0;
  logic     pix_pend = 1'b0;
  pix_exp_t pe_mon;
  int       ra_mon;

  always @(negedge clk_in) begin
    if (pix_pend) begin
      if (pix_q.size() == 0) begin
        n_total++;
        $display("FAIL pix_underflow: got pixel %0b with nothing queued", is_alive_out);
      end else begin
        pe_mon = pix_q.pop_front();
        check($sformatf("pix_h%0d", pe_mon.h), 64'(is_alive_out), 64'(pe_mon.alive));
      end
    end
    pix_pend = pix_chk;
  end

  always @(negedge clk_in) begin
    if (rd_en_out) begin
      if (rd_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_spurious: got read of addr %0d, required no read", addr_r_out);
      end else begin
        ra_mon = rd_q.pop_front();
        check("rd_addr", 64'(addr_r_out), 64'(ra_mon));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alive"},    64'(is_alive_out), 64'd0);
    check({tag, "_busy"},     64'(busy_out),     64'd0);
    check({tag, "_underrun"}, 64'(underrun_out), 64'd0);
    check({tag, "_rd_en"},    64'(rd_en_out),    64'd0);
    check({tag, "_addr"},     64'(addr_r_out),   64'd0);
  endtask

  task automatic fetch_line(input int vline);
    vcount_in = 10'(vline);
    for (int h = H_ACTIVE; h < H_ACTIVE + 16; h++) begin
      hcount_in = 11'(h);
      tick();
    end
    hcount_in = 11'(H_TOTAL - 1);
    tick();
    hcount_in = 11'd1100;
  endtask

  task automatic display_line(input int vline, input logic [63:0] expv);
    pix_exp_t pe;
    vcount_in = 10'(vline);
    for (int h = 0; h < H_ACTIVE; h++) begin
      hcount_in = 11'(h);
      pe.h      = h;
      pe.alive  = expv[63 - (h >> LOG_CELL_SIZE)];
      pix_q.push_back(pe);
      pix_chk = 1'b1;
      tick();
    end
    pix_chk   = 1'b0;
    hcount_in = 11'd1100;
  endtask

  logic [63:0] exp_edge0, exp_edge96;

  initial begin
    for (int i = 0; i < (1 << LOG_MAX_ADDR); i++) mem[i] = '0;

    #2 rst_n_in = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n_in = 1'b1;
    tick();

    // Both buffers come out of reset dead.
    display_line(0, 64'h0);

    // Aligned view.
    mem[0] = 32'h8000_0001; mem[1] = 32'h0; mem[2] = 32'h0;
    view_x_in = 8'd0; view_y_in = 8'd0;
    rd_q.push_back(0); rd_q.push_back(1); rd_q.push_back(2);
    fetch_line(V_TOTAL - 1);
    display_line(0, 64'h8000_0001_0000_0000);

    // Unaligned view, vx=5.
    mem[0] = 32'h0400_0000; mem[1] = 32'h8000_0001; mem[2] = 32'hC000_0000;
    view_x_in = 8'd5;
    rd_q.push_back(0); rd_q.push_back(1); rd_q.push_back(2);
    fetch_line(V_TOTAL - 1);
    display_line(0, 64'h8000_0010_0000_0038);

    // Board edge, vx=240 vy=250.
    mem[2007] = 32'h0000_8001; mem[2000] = 32'h8000_0000; mem[2001] = 32'h8000_0000; mem[7] = 32'h0;
    view_x_in = 8'd240; view_y_in = 8'd250;
`ifdef TORUS_WRAP_EN
    rd_q.push_back(2007); rd_q.push_back(2000); rd_q.push_back(2001);
    exp_edge0  = 64'h8001_8000_0000_8000;
    exp_edge96 = 64'h0000_0400_0000_8000;
`else
    rd_q.push_back(2007);
    exp_edge0  = 64'h8001_0000_0000_0000;
    exp_edge96 = 64'h0;
`endif
    fetch_line(V_TOTAL - 1);
    display_line(0, exp_edge0);

    // Mid-frame view changes are ignored; line 96 maps to board row 256.
    view_x_in = 8'd0; view_y_in = 8'd0;
`ifdef TORUS_WRAP_EN
    rd_q.push_back(7); rd_q.push_back(0); rd_q.push_back(1);
`endif
    fetch_line(95);
    display_line(96, exp_edge96);
    check("underrun_before", 64'(underrun_out), 64'd0);

    // Swap arrives one cycle after the trigger: fetch cannot finish.
    view_x_in = 8'd240; view_y_in = 8'd250;
    rd_q.push_back(2007);
    vcount_in = 10'(V_TOTAL - 1);
    hcount_in = 11'(H_ACTIVE);
    tick();
    hcount_in = 11'(H_TOTAL - 1);
    tick();
    hcount_in = 11'd1100;
    check("underrun_set", 64'(underrun_out), 64'd1);
    display_line(0, 64'h0);

    // A clean fetch afterwards recovers the picture but the flag stays.
`ifdef TORUS_WRAP_EN
    rd_q.push_back(2007); rd_q.push_back(2000); rd_q.push_back(2001);
`else
    rd_q.push_back(2007);
`endif
    fetch_line(0);
    check("underrun_sticky", 64'(underrun_out), 64'd1);
    display_line(1, exp_edge0);

    // Reset while reads are in flight.
    mem[0] = 32'h8000_0001; mem[1] = 32'h0; mem[2] = 32'h0;
    view_x_in = 8'd0; view_y_in = 8'd0;
    rd_q.push_back(0); rd_q.push_back(1); rd_q.push_back(2);
    vcount_in = 10'(V_TOTAL - 1);
    for (int h = H_ACTIVE; h < H_ACTIVE + 4; h++) begin
      hcount_in = 11'(h);
      tick();
    end
    hcount_in = 11'(H_ACTIVE + 4);
    check("busy_in_drain", 64'(busy_out), 64'd1);
    rst_n_in = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
    rd_q.push_back(0); rd_q.push_back(1); rd_q.push_back(2);
    fetch_line(V_TOTAL - 1);
    display_line(0, 64'h8000_0001_0000_0000);

    tick();
    tick();
    check("rd_queue_empty",  64'(rd_q.size()),  64'd0);
    check("pix_queue_empty", 64'(pix_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
